// File: rtl/gf2m_divider_seq_pkg.sv
// Shared defaults, FSM state encoding and the degree priority encoder
// for the sequential GF(2^M) divider.
package gf2m_pkg;

  localparam int             M_DEF    = 163;
  localparam logic [162:0]   POLY_DEF = 163'hC9;   // x^163 + x^7 + x^6 + x^3 + 1

  // Widest u/v vector deg_of() accepts (M+1 must not exceed this).
  localparam int             DEG_MAX  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Index of the most significant set bit; 0 for an all-zero vector.
  function automatic int deg_of(input logic [DEG_MAX-1:0] vec);
    int d;
    d = 0;
    for (int i = 0; i < DEG_MAX; i++) begin
      if (vec[i]) d = i;
    end
    return d;
  endfunction

endpackage

// File: rtl/gf2m_divider_seq_if.sv
// Start/done request bus of the divider: operands in, quotient and status out.
interface gf2m_divider_seq_if #(
  parameter int M = 163
);
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         ready;
  logic         done;
  logic [M-1:0] c;
  logic         div_zero;

  modport master (output start, a, b, input  ready, done, c, div_zero);
  modport slave  (input  start, a, b, output ready, done, c, div_zero);
endinterface

// File: rtl/gf2m_divider_seq_halve.sv
// Combinational halving in GF(2^M): g/x mod f. An odd g has f added first so
// the shift is exact; f's implied x^M term lands in the top result bit.
module gf2m_halve #(
  parameter int           M    = 163,
  parameter logic [M-1:0] POLY = M'(gf2m_pkg::POLY_DEF)
) (
  input  logic [M-1:0] g_i,
  output logic [M-1:0] h_o
);

  // Bit 0 of f is 1 for any irreducible f, so (g ^ f)[0] is 0 when g is odd.
  assign h_o = g_i[0] ? {1'b1, g_i[M-1:1] ^ POLY[M-1:1]}
                      : {1'b0, g_i[M-1:1]};

endmodule

// File: rtl/gf2m_divider_seq.sv
// Sequential GF(2^M) divider, c = a / b mod f, binary Euclidean algorithm.
// Invariants while running: g1*b == a*u and g2*b == a*v (mod f); whichever of
// u, v first reaches 1 carries the quotient in its companion g register.
module gf2m_divider_seq
  import gf2m_pkg::*;
#(
  parameter int           M    = M_DEF,
  parameter logic [M-1:0] POLY = M'(POLY_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  gf2m_divider_seq_if.slave bus
);

  localparam logic [M:0] F_POLY = {1'b1, POLY};
  localparam logic [M:0] ONE    = (M+1)'(1);

  state_e       state_q, state_d;
  logic [M:0]   u_q, u_d, v_q, v_d;
  logic [M-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [M-1:0] c_q, c_d;
  logic         dz_q, dz_d;

  logic [M-1:0] g1_half, g2_half;
  logic         b_zero;
  logic         u_one, v_one;
  logic [DEG_MAX-1:0] u_ext, v_ext;
  int           deg_u, deg_v;

  gf2m_halve #(.M(M), .POLY(POLY)) u_halve_g1 (.g_i(g1_q), .h_o(g1_half));
  gf2m_halve #(.M(M), .POLY(POLY)) u_halve_g2 (.g_i(g2_q), .h_o(g2_half));

  assign b_zero = (bus.b == '0);
  assign u_one  = (u_q == ONE);
  assign v_one  = (v_q == ONE);

  // Degree of u and v for the subtract-direction decision.
  always_comb begin
    u_ext        = '0;
    v_ext        = '0;
    u_ext[M:0]   = u_q;
    v_ext[M:0]   = v_q;
    deg_u        = deg_of(u_ext);
    deg_v        = deg_of(v_ext);
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state: zero divisor skips straight to FINISH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = b_zero ? FINISH : RUN;
      RUN:     if (u_one || v_one) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath update: operand load, one Euclidean micro-step per RUN cycle,
  // result capture only on entry to FINISH.
  always_comb begin
    u_d  = u_q;
    v_d  = v_q;
    g1_d = g1_q;
    g2_d = g2_q;
    c_d  = c_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (b_zero) begin
            c_d  = '0;
            dz_d = 1'b1;
          end else begin
            u_d  = {1'b0, bus.b};
            v_d  = F_POLY;
            g1_d = bus.a;
            g2_d = '0;
            dz_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (u_one) begin
          c_d = g1_q;
        end else if (v_one) begin
          c_d = g2_q;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = g1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = g2_half;
        end else if (deg_u > deg_v) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake decoded from state, result straight from registers.
  always_comb begin
    bus.ready    = (state_q == IDLE);
    bus.done     = (state_q == FINISH);
    bus.c        = c_q;
    bus.div_zero = dz_q;
  end

endmodule

// File: tb/tb_gf2m_divider_seq.sv
// Directed checks on an AES-field (M=8) instance and random inverse-product
// checks on the default M=163 instance.
module tb_gf2m_divider_seq;

  localparam int           M8     = 8;
  localparam logic [7:0]   POLY8  = 8'h1B;
  localparam int           M163   = 163;
  localparam logic [162:0] POLY163 = 163'hC9;
  localparam int           LIM8   = 4*M8 + 2 + 8;
  localparam int           LIM163 = 4*M163 + 2 + 8;
  localparam int           NRAND  = 40;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  gf2m_divider_seq_if #(.M(M8))   if8 ();
  gf2m_divider_seq_if #(.M(M163)) if163 ();

  gf2m_divider_seq #(.M(M8), .POLY(POLY8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  gf2m_divider_seq #(.M(M163), .POLY(POLY163)) dut163 (
    .clk   (clk),
    .reset (reset),
    .bus   (if163)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for done on the M=8 instance; lat counts edges from the accepting edge.
  task automatic wait8(inout int lat);
    while (!if8.done && lat < LIM8) begin
      @(negedge clk);
      lat++;
    end
    chk("done8_seen", 256'(if8.done), 256'(1));
  endtask

  task automatic run8(input logic [7:0] aa, input logic [7:0] bb, output int lat);
    @(negedge clk);
    if8.a     = aa;
    if8.b     = bb;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 1;
    wait8(lat);
  endtask

  task automatic run163(input logic [162:0] aa, input logic [162:0] bb, output int lat);
    @(negedge clk);
    if163.a     = aa;
    if163.b     = bb;
    if163.start = 1'b1;
    @(negedge clk);
    if163.start = 1'b0;
    lat = 1;
    while (!if163.done && lat < LIM163) begin
      @(negedge clk);
      lat++;
    end
    chk("done163_seen", 256'(if163.done), 256'(1));
  endtask

  function automatic logic [162:0] mul163(input logic [162:0] x, input logic [162:0] y);
    logic [162:0] r;
    logic [162:0] t;
    r = '0;
    t = x;
    for (int i = 0; i < M163; i++) begin
      if (y[i]) r = r ^ t;
      t = t[162] ? ((t << 1) ^ POLY163) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[162:0];
  endfunction

  initial begin
    int           lat;
    int           ndone;
    logic [162:0] ra, rb;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    if8.start   = 1'b0;
    if8.a       = '0;
    if8.b       = '0;
    if163.start = 1'b0;
    if163.a     = '0;
    if163.b     = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(if8.ready), 256'(1));
    chk("rst_done",  256'(if8.done), 256'(0));
    chk("rst_c",     256'(if8.c), 256'(0));
    chk("rst_dz",    256'(if8.div_zero), 256'(0));
    chk("rst_ready163", 256'(if163.ready), 256'(1));
    reset = 1'b0;

    // 1: inverse of 0x53 in the AES field
    run8(8'h01, 8'h53, lat);
    chk("t1_c",  256'(if8.c), 256'(8'hCA));
    chk("t1_dz", 256'(if8.div_zero), 256'(0));
    chk("t1_lat_bound", 256'(lat <= 4*M8 + 2), 256'(1));

    // result holds while idle even with operand changes
    if8.a = 8'hFF;
    if8.b = 8'hEE;
    repeat (5) @(negedge clk);
    chk("t1_hold_c", 256'(if8.c), 256'(8'hCA));
    chk("t1_hold_done", 256'(if8.done), 256'(0));
    chk("t1_hold_ready", 256'(if8.ready), 256'(1));

    // 2: x / x = 1
    run8(8'h53, 8'h53, lat);
    chk("t2_c", 256'(if8.c), 256'(8'h01));

    // b == 1: quotient is a, minimum latency
    run8(8'h57, 8'h01, lat);
    chk("b1_c",   256'(if8.c), 256'(8'h57));
    chk("b1_lat", 256'(lat), 256'(2));

    // 3: divide by zero
    run8(8'h57, 8'h00, lat);
    chk("t3_c",   256'(if8.c), 256'(0));
    chk("t3_dz",  256'(if8.div_zero), 256'(1));
    chk("t3_lat", 256'(lat <= 2), 256'(1));
    @(negedge clk);
    chk("t3_done_pulse", 256'(if8.done), 256'(0));
    chk("t3_dz_hold", 256'(if8.div_zero), 256'(1));

    // next valid division clears div_zero
    run8(8'h02, 8'h01, lat);
    chk("dz_clear_c",  256'(if8.c), 256'(8'h02));
    chk("dz_clear_dz", 256'(if8.div_zero), 256'(0));

    // 4: zero dividend
    run8(8'h00, 8'h35, lat);
    chk("t4_c",  256'(if8.c), 256'(0));
    chk("t4_dz", 256'(if8.div_zero), 256'(0));

    // 5: start re-pulsed while busy is ignored
    @(negedge clk);
    if8.a     = 8'h01;
    if8.b     = 8'h53;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 1;
    @(negedge clk);
    lat++;
    chk("t5_busy", 256'(if8.ready), 256'(0));
    if8.a     = 8'h53;
    if8.b     = 8'h53;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat++;
    wait8(lat);
    chk("t5_c", 256'(if8.c), 256'(8'hCA));

    // 6: reset mid-run aborts with no done pulse
    @(negedge clk);
    if8.a     = 8'h01;
    if8.b     = 8'h53;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_busy", 256'(if8.ready), 256'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ready", 256'(if8.ready), 256'(1));
    chk("t6_done",  256'(if8.done), 256'(0));
    chk("t6_c",     256'(if8.c), 256'(0));
    chk("t6_dz",    256'(if8.div_zero), 256'(0));
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    chk("t6_no_done", 256'(ndone), 256'(0));
    run8(8'h53, 8'h53, lat);
    chk("t6_recover_c", 256'(if8.c), 256'(8'h01));

    // M=163: random quotients verified by multiplying back
    for (int n = 0; n < NRAND; n++) begin
      ra = rand163();
      rb = rand163();
      if (rb == '0) rb = 163'h1;
      if (n == 0) rb = 163'h1;
      if (n == 1) ra = '0;
      run163(ra, rb, lat);
      chk("r163_prod", 256'(mul163(if163.c, rb)), 256'(ra));
      chk("r163_dz",   256'(if163.div_zero), 256'(0));
      chk("r163_lat",  256'(lat <= 4*M163 + 2), 256'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
